// File: rtl/gray_capture_ctrl_if.sv
// gray_capture_ctrl_if
//   Bundles the sensor stream, capture control and converter-side outputs of
//   gray_capture_ctrl. Clock and reset stay plain ports on the module.
//   master : drives iSTART/iSTOP/iSKIP and the raw sensor stream
//   slave  : the capture controller, drives the registered pixel stream,
//            coordinates, frame counter and status
interface gray_capture_ctrl_if #(
    parameter int SKIP_W = 4
);
    logic              iSTART;
    logic              iSTOP;
    logic [SKIP_W-1:0] iSKIP;
    logic              iFVAL;
    logic              iLVAL;
    logic [11:0]       iDATA;
    logic [11:0]       oDATA;
    logic              oDVAL;
    logic [10:0]       oX_Cont;
    logic [10:0]       oY_Cont;
    logic [31:0]       oFrame_Cont;
    logic [1:0]        oState;
    logic              oBusy;

    modport master (
        output iSTART, iSTOP, iSKIP, iFVAL, iLVAL, iDATA,
        input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oState, oBusy
    );

    modport slave (
        input  iSTART, iSTOP, iSKIP, iFVAL, iLVAL, iDATA,
        output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oState, oBusy
    );
endinterface

// File: rtl/gray_capture_ctrl.sv
// gray_capture_ctrl
//   Frame-level capture controller in front of the Bayer-to-gray converter.
//   Registers the raw sensor stream, arms/stops capture on frame boundaries,
//   decimates frames by iSKIP, and produces pixel X/Y plus data-valid.
// Ports:
//   iCLK  pixel clock
//   iRST  asynchronous active-low reset
//   bus   gray_capture_ctrl_if.slave
//         in : iSTART, iSTOP, iSKIP, iFVAL, iLVAL, iDATA
//         out: oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oState, oBusy
module gray_capture_ctrl #(
    parameter int COLS   = 1280,
    parameter int SKIP_W = 4
) (
    input  logic iCLK,
    input  logic iRST,
    gray_capture_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] CAPTURE  = 2'd2;
    localparam logic [1:0] STOPPING = 2'd3;

    logic [1:0]        state;
    logic              fvalR, fvalPrev, lvalR;
    logic [11:0]       dataR;
    logic              frameEn;
    logic [SKIP_W-1:0] skipCnt;
    logic [10:0]       xCnt, yCnt;
    logic [31:0]       frameCnt;

    logic frameStart, frameEnd, inCap, dval;

    // Edges are taken on the registered FVAL so they line up with oDATA.
    assign frameStart = fvalR & ~fvalPrev;
    assign frameEnd   = ~fvalR & fvalPrev;
    assign inCap      = (state == CAPTURE) || (state == STOPPING);
    assign dval       = frameEn & fvalR & lvalR & inCap;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= IDLE;
            fvalR    <= 1'b0;
            fvalPrev <= 1'b0;
            lvalR    <= 1'b0;
            dataR    <= '0;
            frameEn  <= 1'b0;
            skipCnt  <= '0;
            xCnt     <= '0;
            yCnt     <= '0;
            frameCnt <= '0;
        end else begin
            fvalR    <= bus.iFVAL;
            fvalPrev <= fvalR;
            lvalR    <= bus.iLVAL;
            dataR    <= bus.iDATA;

            // iSTOP has priority over iSTART everywhere it matters.
            case (state)
                IDLE: begin
                    if (bus.iSTART && !bus.iSTOP) begin
                        state   <= ARMED;
                        skipCnt <= '0;
                    end
                end
                ARMED: begin
                    if (bus.iSTOP)
                        state <= IDLE;
                    else if (frameStart)
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    // Mid-frame stop lets the current frame drain.
                    if (bus.iSTOP)
                        state <= fvalR ? STOPPING : IDLE;
                end
                default: begin
                    if (frameEnd)
                        state <= IDLE;
                end
            endcase

            // Decimation: first frame after arming always passes because
            // skipCnt is cleared on arm.
            if (frameStart && (state == ARMED || state == CAPTURE)) begin
                frameEn <= (skipCnt == '0);
                skipCnt <= (skipCnt == '0) ? bus.iSKIP : skipCnt - 1'b1;
            end else if (frameEnd) begin
                frameEn <= 1'b0;
            end

            // Coordinates describe the pixel currently on oDATA, then advance.
            if (frameStart) begin
                xCnt <= '0;
                yCnt <= '0;
            end else if (dval) begin
                if (xCnt == 11'(COLS - 1)) begin
                    xCnt <= '0;
                    if (yCnt != 11'd2047)
                        yCnt <= yCnt + 11'd1;
                end else begin
                    xCnt <= xCnt + 11'd1;
                end
            end

            if (frameEnd && frameEn && inCap)
                frameCnt <= frameCnt + 32'd1;
        end
    end

    assign bus.oDATA       = dataR;
    assign bus.oDVAL       = dval;
    assign bus.oX_Cont     = xCnt;
    assign bus.oY_Cont     = yCnt;
    assign bus.oFrame_Cont = frameCnt;
    assign bus.oState      = state;
    assign bus.oBusy       = (state != IDLE);
endmodule

// File: tb/tb_gray_capture_ctrl.sv
// tb_gray_capture_ctrl
//   Directed sequence with random pixel data. The reference model works at
//   frame granularity: a frame is captured when the controller is active at
//   its start and its index since arming is a multiple of (skip+1); captured
//   pixels are expected with X = pixel-in-line and Y = line number.
module tb_gray_capture_ctrl;
    localparam int COLS  = 4;
    localparam int LINES = 2;
    localparam int FLEN  = 2 + LINES * (COLS + 2);

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    always #5 iCLK = ~iCLK;

    gray_capture_ctrl_if #(.SKIP_W(4)) bus();

    gray_capture_ctrl #(.COLS(COLS), .SKIP_W(4)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    // model: 0 idle, 1 armed, 2 capturing, 3 stopping
    int mState = 0;
    int mIdx   = 0;
    int mSkip  = 0;
    int mCount = 0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_dval"},  32'(bus.oDVAL), 32'd0);
        chk({tag, "_data"},  32'(bus.oDATA), 32'd0);
        chk({tag, "_x"},     32'(bus.oX_Cont), 32'd0);
        chk({tag, "_y"},     32'(bus.oY_Cont), 32'd0);
        chk({tag, "_frame"}, bus.oFrame_Cont, 32'd0);
        chk({tag, "_state"}, 32'(bus.oState), 32'd0);
        chk({tag, "_busy"},  32'(bus.oBusy), 32'd0);
    endtask

    task automatic step(input logic fv, input logic lv, input logic [11:0] d,
                        input logic st, input logic sp);
        bus.iFVAL  = fv;
        bus.iLVAL  = lv;
        bus.iDATA  = d;
        bus.iSTART = st;
        bus.iSTOP  = sp;
        @(posedge iCLK);
        #1;
        bus.iSTART = 1'b0;
        bus.iSTOP  = 1'b0;
    endtask

    task automatic pulse(input logic st, input logic sp);
        step(1'b0, 1'b0, 12'd0, st, sp);
        if (sp) begin
            if (mState == 1 || mState == 2) mState = 0;
        end else if (st && mState == 0) begin
            mState = 1;
            mIdx   = 0;
        end
        chk("pulse_state", 32'(bus.oState), 32'(mState));
        chk("pulse_busy", 32'(bus.oBusy), {31'd0, mState != 0});
    endtask

    // One frame: 2 lead cycles, LINES lines of COLS pixels each followed by
    // 2 blank cycles, then 3 cycles of FVAL low. Events at cycle index c.
    task automatic frame(input int startAt, input int stopAt, input int rstAt);
        bit cap;
        logic lv;
        logic [11:0] d;
        int q, l, p;
        cap = (mState == 1 || mState == 2) && (mIdx % (mSkip + 1) == 0);
        if (mState == 1 || mState == 2) begin
            mIdx++;
            mState = 2;
        end
        for (int c = 0; c < FLEN; c++) begin
            if (c < 2) begin
                lv = 1'b0; l = 0; p = 0;
            end else begin
                q  = c - 2;
                l  = q / (COLS + 2);
                p  = q % (COLS + 2);
                lv = (p < COLS);
            end
            d = 12'($urandom);
            step(1'b1, lv, d, c == startAt, c == stopAt);
            if (c == startAt && mState == 0) begin
                mState = 1;
                mIdx   = 0;
                chk("midstart_state", 32'(bus.oState), 32'd1);
            end
            if (c == stopAt) begin
                if (mState == 1) begin
                    mState = 0;
                    chk("stop_armed_state", 32'(bus.oState), 32'd0);
                end else if (mState == 2) begin
                    mState = 3;
                    chk("stopping_state", 32'(bus.oState), 32'd3);
                end
            end
            chk("dval", 32'(bus.oDVAL), {31'd0, cap && lv});
            if (cap && lv) begin
                chk("data", 32'(bus.oDATA), 32'(d));
                chk("x", 32'(bus.oX_Cont), 32'(p));
                chk("y", 32'(bus.oY_Cont), 32'(l));
            end
            if (c == rstAt) begin
                iRST = 1'b0;
                #1;
                chkZero("rst");
                @(negedge iCLK);
                iRST   = 1'b1;
                mState = 0;
                mCount = 0;
                cap    = 1'b0;
            end
        end
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 12'd0, 1'b0, 1'b0);
            chk("tail_dval", 32'(bus.oDVAL), 32'd0);
            if (mState == 3) begin
                if (t == 0) chk("tail_stopping", 32'(bus.oState), 32'd3);
                if (t == 1) begin
                    chk("tail_idle", 32'(bus.oState), 32'd0);
                    mState = 0;
                end
            end
        end
        if (cap) mCount++;
        chk("frame_cnt", bus.oFrame_Cont, 32'(mCount));
        chk("frame_state", 32'(bus.oState), 32'(mState));
    endtask

    initial begin
        bus.iSTART = 1'b0;
        bus.iSTOP  = 1'b0;
        bus.iSKIP  = 4'd0;
        bus.iFVAL  = 1'b0;
        bus.iLVAL  = 1'b0;
        bus.iDATA  = 12'd0;
        repeat (3) @(posedge iCLK);
        #1;
        chkZero("reset");
        @(negedge iCLK);
        iRST = 1'b1;

        // basic capture, every frame
        mSkip = 0; bus.iSKIP = 4'd0;
        pulse(1'b1, 1'b0);
        frame(-1, -1, -1);
        pulse(1'b0, 1'b1);

        // armed mid-frame: that frame ignored, next one captured from (0,0)
        frame(5, -1, -1);
        frame(-1, -1, -1);
        pulse(1'b0, 1'b1);

        // decimation 1 of 3 over 7 frames
        mSkip = 2; bus.iSKIP = 4'd2;
        pulse(1'b1, 1'b0);
        base = mCount;
        repeat (7) frame(-1, -1, -1);
        chk("skip_frames", bus.oFrame_Cont - 32'(base), 32'd3);
        pulse(1'b0, 1'b1);

        // stop mid-frame: frame completes, then nothing
        mSkip = 0; bus.iSKIP = 4'd0;
        pulse(1'b1, 1'b0);
        frame(-1, 6, -1);
        frame(-1, -1, -1);

        // start+stop together, stop while armed
        pulse(1'b1, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        frame(-1, -1, -1);

        // reset mid-line, then require a new arm and frame start
        pulse(1'b1, 1'b0);
        frame(-1, -1, 4);
        frame(-1, -1, -1);
        pulse(1'b1, 1'b0);
        frame(-1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
